// File: rtl/sbus_pkg.sv
// Shared constants, FSM state type and debug view for the SBUS frame controller.
package sbus_pkg;

  localparam logic [7:0] SBUS_HEADER        = 8'h0F;
  localparam logic [7:0] SBUS_FOOTER        = 8'h00;
  localparam int         SBUS_PAYLOAD_BYTES = 22;
  localparam int         SBUS_WORDS         = 11;
  localparam int         SBUS_PAY_W         = 16 * SBUS_WORDS;

  // Bit positions inside the SBUS flags byte
  localparam int FLAG_CH17_BIT     = 0;
  localparam int FLAG_CH18_BIT     = 1;
  localparam int FLAG_LOST_BIT     = 2;
  localparam int FLAG_FAILSAFE_BIT = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    FLAGS   = 2'd2,
    FOOTER  = 2'd3
  } sbus_state_t;

  typedef struct packed {
    sbus_state_t state;
    logic [4:0]  idx;
    logic        gap_ok;
    logic        link_sat;
    logic        commit;
    logic        drop;
  } sbus_dbg_t;

endpackage

// File: rtl/sbus_gap_timer.sv
// Saturating idle counter: clears on clr, otherwise counts up to MAX_CYCLES and holds.
module sbus_gap_timer #(
  parameter int unsigned MAX_CYCLES = 15000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic sat
);

  localparam int W = $clog2(MAX_CYCLES + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != W'(MAX_CYCLES)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign sat = (cnt == W'(MAX_CYCLES));

endmodule

// File: rtl/sbus_frame_ctrl.sv
// SBUS frame assembler: header/payload/flags/footer framing with gap and link timeouts.
// Optional statistics counters are built only when SBUS_STATS_EN is defined.
module sbus_frame_ctrl
  import sbus_pkg::*;
#(
  parameter int unsigned GAP_CYCLES  = 15000,
  parameter int unsigned LOST_CYCLES = 5000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  rx_err,
  output logic [SBUS_PAY_W-1:0] pay_bus,
  output logic [7:0]            flags,
  output logic                  frame_stb,
  output logic                  failsafe,
  output logic                  frame_lost,
  output logic                  link_ok,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           err_cnt,
  output sbus_dbg_t             dbg
);

  // rx_valid is a one-cycle strobe with no backpressure: a byte is consumed
  // in exactly the cycle rx_valid=1, and rx_data/rx_err are ignored otherwise.

  localparam logic [4:0] LAST_IDX = 5'(SBUS_PAYLOAD_BYTES - 1);

  sbus_state_t           state, state_nxt;
  logic [4:0]            idx;
  logic [SBUS_PAY_W-1:0] shadow_pay;
  logic [7:0]            shadow_flags;
  logic                  gap_ok, link_sat, seen_commit;
  logic                  commit, drop, pay_we, flags_we, abort_cond;

  sbus_gap_timer #(.MAX_CYCLES(GAP_CYCLES)) u_gap (
    .clk   (clk),
    .reset (reset),
    .clr   (rx_valid),
    .sat   (gap_ok)
  );

  sbus_gap_timer #(.MAX_CYCLES(LOST_CYCLES)) u_link (
    .clk   (clk),
    .reset (reset),
    .clr   (commit),
    .sat   (link_sat)
  );

  // Inside a frame, a silent line or a corrupted byte both end the frame
  assign abort_cond = (state != IDLE) && (gap_ok || (rx_valid && rx_err));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort_cond) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (rx_valid && !rx_err && rx_data == SBUS_HEADER && gap_ok) state_nxt = PAYLOAD;
        PAYLOAD: if (rx_valid && idx == LAST_IDX) state_nxt = FLAGS;
        FLAGS:   if (rx_valid) state_nxt = FOOTER;
        FOOTER:  if (rx_valid) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    commit   = 1'b0;
    drop     = 1'b0;
    pay_we   = 1'b0;
    flags_we = 1'b0;
    if (abort_cond) begin
      drop = 1'b1;
    end else begin
      unique case (state)
        PAYLOAD: pay_we   = rx_valid;
        FLAGS:   flags_we = rx_valid;
        FOOTER: begin
          commit = rx_valid && (rx_data == SBUS_FOOTER);
          drop   = rx_valid && (rx_data != SBUS_FOOTER);
        end
        default: ;
      endcase
    end
  end

  // Payload byte idx lands at bit 8*idx: word idx>>1, half idx[0]
  always_ff @(posedge clk) begin
    if (reset) begin
      idx          <= '0;
      shadow_pay   <= '0;
      shadow_flags <= '0;
      pay_bus      <= '0;
      flags        <= '0;
      frame_stb    <= 1'b0;
      seen_commit  <= 1'b0;
    end else begin
      frame_stb <= commit;
      if (pay_we) begin
        shadow_pay[{idx, 3'b000} +: 8] <= rx_data;
        idx                            <= idx + 5'd1;
      end else if (state != PAYLOAD) begin
        idx <= '0;
      end
      if (flags_we) shadow_flags <= rx_data;
      if (commit) begin
        pay_bus     <= shadow_pay;
        flags       <= shadow_flags;
        seen_commit <= 1'b1;
      end
    end
  end

  assign failsafe   = flags[FLAG_FAILSAFE_BIT];
  assign frame_lost = flags[FLAG_LOST_BIT];
  assign link_ok    = seen_commit && !link_sat;

`ifdef SBUS_STATS_EN
  logic [15:0] frame_cnt_q, err_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (commit) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (drop)   err_cnt_q   <= err_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`else
  assign frame_cnt = '0;
  assign err_cnt   = '0;
`endif

  assign dbg = '{state: state, idx: idx, gap_ok: gap_ok, link_sat: link_sat,
                 commit: commit, drop: drop};

endmodule

// File: tb/tb_sbus_frame_ctrl.sv
// Directed bench for sbus_frame_ctrl with GAP_CYCLES=20, LOST_CYCLES=2000.
module tb_sbus_frame_ctrl;
  import sbus_pkg::*;

  localparam int GAP  = 20;
  localparam int LOST = 2000;
`ifdef SBUS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_err = 1'b0;
  logic [175:0] pay_bus;
  logic [7:0]   flags;
  logic         frame_stb, failsafe, frame_lost, link_ok;
  logic [15:0]  frame_cnt, err_cnt;
  sbus_dbg_t    dbg;

  int pass_cnt = 0;
  int total_cnt = 0;
  int stb_seen = 0;
  int s0;
  int exp_frames = 0;
  int exp_errs = 0;
  logic [175:0] exp_pay = '0;
  logic [7:0]   exp_flags = '0;
  logic [15:0]  want;

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_stb === 1'b1) stb_seen++;

  sbus_frame_ctrl #(.GAP_CYCLES(GAP), .LOST_CYCLES(LOST)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_err     (rx_err),
    .pay_bus    (pay_bus),
    .flags      (flags),
    .frame_stb  (frame_stb),
    .failsafe   (failsafe),
    .frame_lost (frame_lost),
    .link_ok    (link_ok),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt),
    .dbg        (dbg)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic e);
    rx_valid = 1'b1;
    rx_data  = d;
    rx_err   = e;
    tick(1);
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic send_payload(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) send_byte(base + 8'(i), 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] base, input logic [7:0] fl, input logic [7:0] ft);
    send_byte(SBUS_HEADER, 1'b0);
    send_payload(base, SBUS_PAYLOAD_BYTES);
    send_byte(fl, 1'b0);
    send_byte(ft, 1'b0);
  endtask

  function automatic logic [175:0] model_pay(input logic [7:0] base);
    logic [175:0] p;
    p = '0;
    for (int i = 0; i < SBUS_PAYLOAD_BYTES; i++) p[i*8 +: 8] = base + 8'(i);
    return p;
  endfunction

  task automatic check_counts(input string tag);
    want = STATS ? 16'(exp_frames) : 16'h0;
    total_cnt++;
    if (frame_cnt !== want) $display("FAIL %s frame_cnt: got %0d want %0d", tag, frame_cnt, want);
    else pass_cnt++;
    want = STATS ? 16'(exp_errs) : 16'h0;
    total_cnt++;
    if (err_cnt !== want) $display("FAIL %s err_cnt: got %0d want %0d", tag, err_cnt, want);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    total_cnt++;
    if (pay_bus !== 176'h0) $display("FAIL reset pay_bus: got %h want 0", pay_bus);
    else pass_cnt++;
    total_cnt++;
    if (flags !== 8'h00) $display("FAIL reset flags: got %h want 00", flags);
    else pass_cnt++;
    total_cnt++;
    if ({frame_stb, link_ok, failsafe, frame_lost} !== 4'b0000)
      $display("FAIL reset status: got %b want 0000", {frame_stb, link_ok, failsafe, frame_lost});
    else pass_cnt++;
    total_cnt++;
    if (dbg.state !== IDLE) $display("FAIL reset state: got %0d want %0d", dbg.state, IDLE);
    else pass_cnt++;
    check_counts("reset");
    reset = 1'b0;
  endtask

  task automatic test_good_frame;
    s0 = stb_seen;
    tick(30);
    send_frame(8'h01, 8'h08, 8'h00);
    exp_frames++;
    exp_pay   = model_pay(8'h01);
    exp_flags = 8'h08;
    total_cnt++;
    if (frame_stb !== 1'b1) $display("FAIL good stb_after_footer: got %b want 1", frame_stb);
    else pass_cnt++;
    total_cnt++;
    if (pay_bus[15:0] !== 16'h0201) $display("FAIL good word0: got %h want 0201", pay_bus[15:0]);
    else pass_cnt++;
    total_cnt++;
    if (pay_bus[175:160] !== 16'h1615) $display("FAIL good word10: got %h want 1615", pay_bus[175:160]);
    else pass_cnt++;
    total_cnt++;
    if (pay_bus !== exp_pay) $display("FAIL good pay_bus: got %h want %h", pay_bus, exp_pay);
    else pass_cnt++;
    total_cnt++;
    if ({flags, failsafe, frame_lost, link_ok} !== {8'h08, 3'b101})
      $display("FAIL good flags/fs/lost/link: got %h %b%b%b want 08 101", flags, failsafe, frame_lost, link_ok);
    else pass_cnt++;
    check_counts("good");
    tick(1);
    total_cnt++;
    if (frame_stb !== 1'b0) $display("FAIL good stb_width: got %b want 0", frame_stb);
    else pass_cnt++;
    total_cnt++;
    if (stb_seen - s0 !== 1) $display("FAIL good stb_count: got %0d want 1", stb_seen - s0);
    else pass_cnt++;
  endtask

  task automatic test_early_header;
    s0 = stb_seen;
    send_byte(8'hAA, 1'b0);
    tick(4);
    send_byte(SBUS_HEADER, 1'b0);
    total_cnt++;
    if (dbg.state !== IDLE) $display("FAIL early state: got %0d want %0d", dbg.state, IDLE);
    else pass_cnt++;
    send_payload(8'h40, SBUS_PAYLOAD_BYTES);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    tick(2);
    total_cnt++;
    if (stb_seen - s0 !== 0) $display("FAIL early stb_count: got %0d want 0", stb_seen - s0);
    else pass_cnt++;
    total_cnt++;
    if (pay_bus !== exp_pay) $display("FAIL early pay_bus: got %h want %h", pay_bus, exp_pay);
    else pass_cnt++;
    check_counts("early");
  endtask

  task automatic test_bad_footer;
    s0 = stb_seen;
    tick(25);
    send_frame(8'h50, 8'h0C, 8'h55);
    exp_errs++;
    tick(1);
    total_cnt++;
    if (stb_seen - s0 !== 0) $display("FAIL badftr stb_count: got %0d want 0", stb_seen - s0);
    else pass_cnt++;
    total_cnt++;
    if ({pay_bus, flags} !== {exp_pay, exp_flags})
      $display("FAIL badftr outputs: got %h %h want %h %h", pay_bus, flags, exp_pay, exp_flags);
    else pass_cnt++;
    check_counts("badftr");
  endtask

  task automatic test_rx_err;
    s0 = stb_seen;
    tick(25);
    send_byte(SBUS_HEADER, 1'b0);
    send_payload(8'h30, 10);
    send_byte(8'h3A, 1'b1);
    exp_errs++;
    total_cnt++;
    if (dbg.state !== IDLE) $display("FAIL rxerr state: got %0d want %0d", dbg.state, IDLE);
    else pass_cnt++;
    check_counts("rxerr_abort");
    tick(25);
    send_frame(8'h60, 8'h04, 8'h00);
    exp_frames++;
    exp_pay   = model_pay(8'h60);
    exp_flags = 8'h04;
    tick(1);
    total_cnt++;
    if (stb_seen - s0 !== 1) $display("FAIL rxerr stb_count: got %0d want 1", stb_seen - s0);
    else pass_cnt++;
    total_cnt++;
    if (pay_bus[15:0] !== 16'h6160) $display("FAIL rxerr word0: got %h want 6160", pay_bus[15:0]);
    else pass_cnt++;
    total_cnt++;
    if ({flags, failsafe, frame_lost} !== {8'h04, 2'b01})
      $display("FAIL rxerr flags/fs/lost: got %h %b%b want 04 01", flags, failsafe, frame_lost);
    else pass_cnt++;
    check_counts("rxerr_frame");
  endtask

  task automatic test_stall;
    s0 = stb_seen;
    tick(25);
    send_byte(SBUS_HEADER, 1'b0);
    send_payload(8'h20, 8);
    tick(GAP - 1);
    total_cnt++;
    if (dbg.state !== PAYLOAD) $display("FAIL stall state_before: got %0d want %0d", dbg.state, PAYLOAD);
    else pass_cnt++;
    check_counts("stall_before");
    tick(2);
    exp_errs++;
    total_cnt++;
    if (dbg.state !== IDLE) $display("FAIL stall state_after: got %0d want %0d", dbg.state, IDLE);
    else pass_cnt++;
    check_counts("stall_after");
    total_cnt++;
    if (stb_seen - s0 !== 0) $display("FAIL stall stb_count: got %0d want 0", stb_seen - s0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame;
    tick(6);
    send_byte(SBUS_HEADER, 1'b0);
    send_payload(8'h70, 5);
    s0 = stb_seen;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    exp_pay = '0;
    exp_flags = '0;
    exp_frames = 0;
    exp_errs = 0;
    total_cnt++;
    if ({pay_bus, flags} !== 184'h0) $display("FAIL midrst outputs: got %h %h want 0", pay_bus, flags);
    else pass_cnt++;
    total_cnt++;
    if ({frame_stb, link_ok, failsafe, frame_lost} !== 4'b0000)
      $display("FAIL midrst status: got %b want 0000", {frame_stb, link_ok, failsafe, frame_lost});
    else pass_cnt++;
    check_counts("midrst");
    send_payload(8'h75, 17);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    tick(5);
    send_frame(8'h01, 8'h08, 8'h00);
    tick(2);
    total_cnt++;
    if (stb_seen - s0 !== 0) $display("FAIL midrst stb_count: got %0d want 0", stb_seen - s0);
    else pass_cnt++;
    total_cnt++;
    if (pay_bus !== 176'h0) $display("FAIL postrst_gap pay_bus: got %h want 0", pay_bus);
    else pass_cnt++;
    check_counts("postrst_gap");
  endtask

  task automatic test_link_loss;
    s0 = stb_seen;
    tick(25);
    send_frame(8'h10, 8'h00, 8'h00);
    exp_frames++;
    exp_pay = model_pay(8'h10);
    total_cnt++;
    if ({link_ok, pay_bus} !== {1'b1, exp_pay}) $display("FAIL link first: got %b %h want 1 %h", link_ok, pay_bus, exp_pay);
    else pass_cnt++;
    tick(LOST - 2);
    total_cnt++;
    if (link_ok !== 1'b1) $display("FAIL link before_loss: got %b want 1", link_ok);
    else pass_cnt++;
    tick(2);
    total_cnt++;
    if (link_ok !== 1'b0) $display("FAIL link lost: got %b want 0", link_ok);
    else pass_cnt++;
    send_frame(8'h90, 8'h00, 8'h00);
    exp_frames++;
    exp_pay = model_pay(8'h90);
    total_cnt++;
    if ({link_ok, pay_bus} !== {1'b1, exp_pay}) $display("FAIL link regain: got %b %h want 1 %h", link_ok, pay_bus, exp_pay);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (stb_seen - s0 !== 2) $display("FAIL link stb_count: got %0d want 2", stb_seen - s0);
    else pass_cnt++;
    check_counts("link");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_early_header();
    test_bad_footer();
    test_rx_err();
    test_stall();
    test_reset_mid_frame();
    test_link_loss();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
